// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encoding, default
// timeout and requester identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts cycles a grant has waited for its memory acknowledge and flags the
// cycle in which the wait reaches LIMIT.
module arb_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != W'(LIMIT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // Fires during the LIMIT-th waiting cycle so the grant lasts exactly LIMIT cycles.
    assign expired = enable && (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch
// and a data requester, with a per-grant acknowledge timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    arb_state_t state_reg;
    req_id_t    last_grant_reg;
    req_id_t    pick;
    logic       in_grant;
    logic       wait_clear;
    logic       wait_enable;
    logic       wait_expired;

    assign in_grant    = (state_reg == GRANT_I) || (state_reg == GRANT_D);
    assign wait_clear  = !in_grant;
    assign wait_enable = in_grant && !mem_ack;

    arb_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .enable (wait_enable),
        .expired(wait_expired)
    );

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = REQ_IF;
        if (d_req && (!if_req || (last_grant_reg == REQ_IF))) begin
            pick = REQ_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= REQ_IF;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            if_ready       <= 1'b0;
            if_err         <= 1'b0;
            if_rdata       <= '0;
            d_ready        <= 1'b0;
            d_err          <= 1'b0;
            d_rdata        <= '0;
        end else begin
            if_ready <= 1'b0;
            if_err   <= 1'b0;
            d_ready  <= 1'b0;
            d_err    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (if_req || d_req) begin
                        mem_req <= 1'b1;
                        if (pick == REQ_D) begin
                            state_reg <= GRANT_D;
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end else begin
                            state_reg <= GRANT_I;
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    // An acknowledge in the expiring cycle still counts as success.
                    if (mem_ack || wait_expired) begin
                        state_reg      <= RESP;
                        mem_req        <= 1'b0;
                        mem_we         <= 1'b0;
                        last_grant_reg <= (state_reg == GRANT_D) ? REQ_D : REQ_IF;
                        if (state_reg == GRANT_I) begin
                            if_ready <= 1'b1;
                            if_err   <= !mem_ack;
                            if_rdata <= mem_ack ? mem_rdata : 32'h0;
                        end else begin
                            d_ready <= 1'b1;
                            d_err   <= !mem_ack;
                            if (!mem_we) begin
                                d_rdata <= mem_ack ? mem_rdata : 32'h0;
                            end
                        end
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
